// File: rtl/mbist_pkg.sv
// Shared BIST types: controller state encoding, read-pipeline entry and default widths.
// The default widths are the same ones the write-side mode mux uses.
package mbist_pkg;

    localparam int MBIST_ADDR_W = 4;
    localparam int MBIST_DATA_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mbist_state_t;

    typedef struct packed {
        logic                    valid;
        logic [MBIST_ADDR_W-1:0] addr;
        logic [MBIST_DATA_W-1:0] exp;
    } rd_ent_t;

endpackage

// File: rtl/mbist_rd_pipe.sv
// Delay line that carries outstanding BIST read requests until their data returns.
// Latency pDEPTH cycles; no backpressure; a flush empties every stage and beats the shift.
module mbist_rd_pipe
    import mbist_pkg::*;
#(
    parameter int  pDEPTH = 1,
    parameter type T      = rd_ent_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_flush,
    input  T     i_ent,
    output T     o_head
);

    T r_stage [pDEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < pDEPTH; i++) r_stage[i] <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < pDEPTH; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_ent;
            for (int i = 1; i < pDEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_head = r_stage[pDEPTH-1];

endmodule

// File: rtl/mbist_resp_chk.sv
// Memory read-response checker: functional passthrough, or BIST compare with first-fail capture.
// Latency pRD_LAT cycles from read request to compare, results one edge later; never stalls.
// Optional accumulated failing-bit mask enabled by macro MBIST_FAIL_BITMAP_EN.
module mbist_resp_chk
    import mbist_pkg::*;
#(
    parameter int pADDR_WIDTH = MBIST_ADDR_W,
    parameter int pDATA_WIDTH = MBIST_DATA_W,
    parameter int pRD_LAT     = 1,
    parameter int pERR_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode,
    input  logic                   bist_start,
    input  logic                   bist_cs,
    input  logic                   bist_we,
    input  logic [pADDR_WIDTH-1:0] bist_addr,
    input  logic [pDATA_WIDTH-1:0] bist_exp,
    input  logic                   bist_last,
    input  logic [pDATA_WIDTH-1:0] mem_dout,
    output logic [pDATA_WIDTH-1:0] func_dout,
    output logic                   bist_busy,
    output logic                   bist_done,
    output logic                   bist_fail,
    output logic [pADDR_WIDTH-1:0] fail_addr,
    output logic [pDATA_WIDTH-1:0] fail_exp,
    output logic [pDATA_WIDTH-1:0] fail_act,
    output logic [pERR_WIDTH-1:0]  err_cnt,
    output logic [pDATA_WIDTH-1:0] fail_bits
);

    localparam int CNT_W = $clog2(pRD_LAT + 1);

    typedef struct packed {
        logic                   valid;
        logic [pADDR_WIDTH-1:0] addr;
        logic [pDATA_WIDTH-1:0] exp;
    } ent_t;

    mbist_state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]        r_drain_cnt, w_drain_nxt;
    logic                    w_start, w_abort, w_flush, w_cmp, w_mis;
    ent_t                    w_push, w_head;
    logic                    r_fail;
    logic [pADDR_WIDTH-1:0]  r_fail_addr;
    logic [pDATA_WIDTH-1:0]  r_fail_exp, r_fail_act;
    logic [pERR_WIDTH-1:0]   r_err_cnt;

    assign w_start = mode & bist_start;
    assign w_abort = ~mode & ((r_state == RUN) | (r_state == DRAIN));
    assign w_flush = w_start | w_abort;

    assign w_push.valid = (r_state == RUN) & mode & bist_cs & ~bist_we;
    assign w_push.addr  = bist_addr;
    assign w_push.exp   = bist_exp;

    mbist_rd_pipe #(.pDEPTH(pRD_LAT), .T(ent_t)) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_ent   (w_push),
        .o_head  (w_head)
    );

    // A start in the same cycle as a head compare discards that compare.
    assign w_cmp = w_head.valid & mode & ~bist_start;
    assign w_mis = w_cmp & (mem_dout != w_head.exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        if (w_start) begin
            w_state_nxt = RUN;
            w_drain_nxt = '0;
        end else if (w_abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                RUN: if (bist_cs & bist_last) begin
                    w_state_nxt = DRAIN;
                    w_drain_nxt = CNT_W'(pRD_LAT);
                end
                DRAIN: if (r_drain_cnt == CNT_W'(1)) w_state_nxt = DONE;
                       else w_drain_nxt = r_drain_cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_exp  <= '0;
            r_fail_act  <= '0;
            r_err_cnt   <= '0;
        end else if (w_start) begin
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_exp  <= '0;
            r_fail_act  <= '0;
            r_err_cnt   <= '0;
        end else if (w_mis) begin
            r_fail <= 1'b1;
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + pERR_WIDTH'(1);
            if (!r_fail) begin
                r_fail_addr <= w_head.addr;
                r_fail_exp  <= w_head.exp;
                r_fail_act  <= mem_dout;
            end
        end
    end

`ifdef MBIST_FAIL_BITMAP_EN
    logic [pDATA_WIDTH-1:0] r_fail_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_fail_bits <= '0;
        else if (w_start) r_fail_bits <= '0;
        else if (w_cmp)  r_fail_bits <= r_fail_bits | (mem_dout ^ w_head.exp);
    end

    assign fail_bits = r_fail_bits;
`else
    assign fail_bits = '0;
`endif

    assign func_dout = mode ? '0 : mem_dout;
    assign bist_busy = (r_state == RUN) | (r_state == DRAIN);
    assign bist_done = (r_state == DONE);
    assign bist_fail = r_fail;
    assign fail_addr = r_fail_addr;
    assign fail_exp  = r_fail_exp;
    assign fail_act  = r_fail_act;
    assign err_cnt   = r_err_cnt;

endmodule
